// File: rtl/seq_divider.sv
// Iterative radix-2 restoring divider with start/done handshake.
// Produces a WIDTH-bit quotient and remainder over WIDTH steps, with RISC-V
// results for divide-by-zero and signed MIN / -1.
//
// state   | meaning
// --------+------------------------------------------------------------
// IDLE    | waiting for start; operands and magnitudes latched on accept
// CALC    | one restoring step per cycle, WIDTH steps in total
// SPECIAL | divide-by-zero or signed overflow; fixed result written on exit
// FIX     | apply result signs; quotient/remainder written on exit
//
// Results are registered on the edge that leaves SPECIAL/FIX, so done is high
// in the following cycle while the FSM is already back in IDLE. busy covers
// that done cycle as well, which is why a start there is ignored.
module seq_divider #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sign,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quot,
  output logic [WIDTH-1:0] rem,
  output logic             div_zero,
  output logic             overflow
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
  localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CALC    = 2'd1,
    SPECIAL = 2'd2,
    FIX     = 2'd3
  } state_t;

  state_t state, state_nxt;

  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] bmag;
  logic [WIDTH-1:0] dq;
  logic [WIDTH-1:0] pr;
  logic [CW-1:0]    cnt;
  logic             qneg;
  logic             rneg;
  logic             dz_q;

  logic             accept;
  logic             is_dz;
  logic             is_ovf;
  logic [WIDTH-1:0] amag_in;
  logic [WIDTH-1:0] bmag_in;
  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   trial;

  // Accept decision, special-case detection and next-state selection
  always_comb begin
    accept    = (state == IDLE) && !done && start;
    is_dz     = (b == '0);
    is_ovf    = sign && (a == MIN_VAL) && (b == '1);
    state_nxt = state;
    case (state)
      IDLE: begin
        if (accept) begin
          state_nxt = (is_dz || is_ovf) ? SPECIAL : CALC;
        end
      end
      CALC: begin
        if (cnt == CNT_LAST) begin
          state_nxt = FIX;
        end
      end
      SPECIAL: state_nxt = IDLE;
      FIX:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Operand magnitudes and the restoring trial subtraction (WIDTH+1 bits)
  always_comb begin
    amag_in = (sign && a[WIDTH-1]) ? -a : a;
    bmag_in = (sign && b[WIDTH-1]) ? -b : b;
    shifted = {pr, dq[WIDTH-1]};
    trial   = shifted - {1'b0, bmag};
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Datapath: operand latch, restoring steps, result and flag write-back
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q      <= '0;
      bmag     <= '0;
      dq       <= '0;
      pr       <= '0;
      cnt      <= '0;
      qneg     <= 1'b0;
      rneg     <= 1'b0;
      dz_q     <= 1'b0;
      done     <= 1'b0;
      quot     <= '0;
      rem      <= '0;
      div_zero <= 1'b0;
      overflow <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            a_q  <= a;
            dz_q <= is_dz;
            dq   <= amag_in;
            bmag <= bmag_in;
            pr   <= '0;
            cnt  <= '0;
            qneg <= sign && (a[WIDTH-1] ^ b[WIDTH-1]);
            rneg <= sign && a[WIDTH-1];
          end
        end
        CALC: begin
          // The top bit of the trial is its borrow: set means the shifted
          // remainder was smaller than the divisor, so restore it.
          if (trial[WIDTH]) begin
            pr <= shifted[WIDTH-1:0];
            dq <= {dq[WIDTH-2:0], 1'b0};
          end else begin
            pr <= trial[WIDTH-1:0];
            dq <= {dq[WIDTH-2:0], 1'b1};
          end
          cnt <= cnt + 1'b1;
        end
        FIX: begin
          quot     <= qneg ? -dq : dq;
          rem      <= rneg ? -pr : pr;
          div_zero <= 1'b0;
          overflow <= 1'b0;
          done     <= 1'b1;
        end
        SPECIAL: begin
          if (dz_q) begin
            quot     <= '1;
            rem      <= a_q;
            div_zero <= 1'b1;
            overflow <= 1'b0;
          end else begin
            quot     <= a_q;
            rem      <= '0;
            div_zero <= 1'b0;
            overflow <= 1'b1;
          end
          done <= 1'b1;
        end
        default: begin
          done <= 1'b0;
        end
      endcase
    end
  end

  // Busy spans the whole operation including the done cycle
  always_comb begin
    busy = (state != IDLE) || done;
  end

endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider: reference model built from plain
// integer division plus a latency countdown, compared every cycle.
module tb_seq_divider;

  localparam int W = 32;
  localparam logic [31:0] MINV = 32'h8000_0000;

  logic          clk = 1'b0;
  logic          rst;
  logic          start = 1'b0;
  logic [W-1:0]  a = '0;
  logic [W-1:0]  b = '0;
  logic          sign = 1'b0;
  logic          busy;
  logic          done;
  logic [W-1:0]  quot;
  logic [W-1:0]  rem;
  logic          div_zero;
  logic          overflow;

  int n_checks = 0;
  int n_errors = 0;

  seq_divider #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .a        (a),
    .b        (b),
    .sign     (sign),
    .busy     (busy),
    .done     (done),
    .quot     (quot),
    .rem      (rem),
    .div_zero (div_zero),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  // Reference: {div_zero, overflow, quot, rem}
  function automatic logic [65:0] ref_div(input logic [31:0] x, input logic [31:0] y,
                                          input logic s);
    logic [31:0] q;
    logic [31:0] r;
    longint sx;
    longint sy;
    if (y == 32'd0) begin
      return {1'b1, 1'b0, 32'hFFFF_FFFF, x};
    end
    if (s && x == MINV && y == 32'hFFFF_FFFF) begin
      return {1'b0, 1'b1, x, 32'd0};
    end
    if (s) begin
      sx = longint'($signed(x));
      sy = longint'($signed(y));
      q  = 32'(sx / sy);
      r  = 32'(sx % sy);
    end else begin
      q = x / y;
      r = x % y;
    end
    return {1'b0, 1'b0, q, r};
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Behavioural model: outputs held, done after a fixed number of edges
  logic [31:0] m_quot = '0, m_rem = '0, p_quot = '0, p_rem = '0;
  logic        m_dz = 1'b0, m_ov = 1'b0, p_dz = 1'b0, p_ov = 1'b0, m_done = 1'b0;
  int          m_left = 0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_quot = '0; m_rem = '0; m_dz = 1'b0; m_ov = 1'b0;
      m_done = 1'b0; m_left = 0;
    end else if (m_left > 0) begin
      m_left = m_left - 1;
      m_done = 1'b0;
      if (m_left == 0) begin
        m_quot = p_quot; m_rem = p_rem; m_dz = p_dz; m_ov = p_ov;
        m_done = 1'b1;
      end
    end else if (m_done) begin
      m_done = 1'b0;
    end else if (start) begin
      {p_dz, p_ov, p_quot, p_rem} = ref_div(a, b, sign);
      m_left = (p_dz || p_ov) ? 1 : W + 1;
    end
  end

  // Per-cycle comparison of every output against the model
  always @(negedge clk) begin
    check("done", 32'(done), 32'(m_done));
    check("busy", 32'(busy), 32'((m_left > 0) || m_done));
    check("quot", quot, m_quot);
    check("rem", rem, m_rem);
    check("div_zero", 32'(div_zero), 32'(m_dz));
    check("overflow", 32'(overflow), 32'(m_ov));
  end

  // Issue one operation and wait for done; optionally pin literal results.
  task automatic do_op(input logic [31:0] ta, input logic [31:0] tb_v, input logic ts,
                       input bit lit, input logic [31:0] eq, input logic [31:0] er,
                       input logic edz, input logic eov, input int elat, input string nm);
    int j;
    logic [65:0] r;
    @(negedge clk);
    start = 1'b1; a = ta; b = tb_v; sign = ts;
    @(negedge clk);
    start = 1'b0; a = $urandom; b = $urandom; sign = 1'($urandom_range(0, 1));
    j = 0;
    while (!done && j < 100) begin
      @(negedge clk);
      j++;
    end
    if (!done) begin
      n_checks++;
      n_errors++;
      $display("FAIL %s timeout: no done after %0d cycles", nm, j);
      return;
    end
    if (lit) begin
      r = ref_div(ta, tb_v, ts);
      check({nm, " model quot"}, r[63:32], eq);
      check({nm, " model rem"}, r[31:0], er);
      check({nm, " latency"}, 32'(j), 32'(elat));
      check({nm, " quot"}, quot, eq);
      check({nm, " rem"}, rem, er);
      check({nm, " div_zero"}, 32'(div_zero), 32'(edz));
      check({nm, " overflow"}, 32'(overflow), 32'(eov));
    end
  endtask

  initial begin
    int j;
    logic [31:0] ra, rb;
    logic rs;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("reset busy", 32'(busy), 32'd0);
    check("reset done", 32'(done), 32'd0);
    check("reset quot", quot, 32'd0);
    check("reset rem", rem, 32'd0);
    rst = 1'b0;

    do_op(32'd100, 32'd7, 1'b0, 1, 32'd14, 32'd2, 1'b0, 1'b0, W + 1, "udiv");
    do_op(32'hFFFF_FFF9, 32'd2, 1'b1, 1, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0, 1'b0, W + 1, "sdiv1");
    do_op(32'd7, 32'hFFFF_FFFE, 1'b1, 1, 32'hFFFF_FFFD, 32'd1, 1'b0, 1'b0, W + 1, "sdiv2");
    do_op(32'h1234_5678, 32'd0, 1'b0, 1, 32'hFFFF_FFFF, 32'h1234_5678, 1'b1, 1'b0, 1, "dz_u");
    do_op(32'h1234_5678, 32'd0, 1'b1, 1, 32'hFFFF_FFFF, 32'h1234_5678, 1'b1, 1'b0, 1, "dz_s");
    do_op(MINV, 32'hFFFF_FFFF, 1'b1, 1, MINV, 32'd0, 1'b0, 1'b1, 1, "ovf");
    do_op(MINV, 32'hFFFF_FFFF, 1'b0, 1, 32'd0, MINV, 1'b0, 1'b0, W + 1, "min_u");
    do_op(32'd0, 32'd9, 1'b1, 1, 32'd0, 32'd0, 1'b0, 1'b0, W + 1, "zero_a");
    do_op(32'd5, 32'd9, 1'b0, 1, 32'd0, 32'd5, 1'b0, 1'b0, W + 1, "b_gt_a");

    // Starts while busy and in the done cycle must be ignored
    @(negedge clk);
    start = 1'b1; a = 32'd1000; b = 32'd3; sign = 1'b0;
    @(negedge clk);
    start = 1'b0;
    j = 0;
    while (!done && j < 100) begin
      @(negedge clk);
      j++;
      if (!done) begin
        if (j == 5 || j == 20) begin
          start = 1'b1; a = $urandom; b = $urandom | 32'd1; sign = 1'b0;
        end else begin
          start = 1'b0;
        end
      end
    end
    check("hs latency", 32'(j), 32'(W + 1));
    check("hs quot", quot, 32'd333);
    check("hs rem", rem, 32'd1);
    start = 1'b1; a = 32'd55; b = 32'd5; sign = 1'b0;
    do_op(32'd7, 32'hFFFF_FFFE, 1'b1, 1, 32'hFFFF_FFFD, 32'd1, 1'b0, 1'b0, W + 1, "b2b");

    // Reset in the middle of CALC aborts the division
    @(negedge clk);
    start = 1'b1; a = 32'd100; b = 32'd7; sign = 1'b0;
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("rst busy", 32'(busy), 32'd0);
    check("rst done", 32'(done), 32'd0);
    check("rst quot", quot, 32'd0);
    check("rst rem", rem, 32'd0);
    check("rst div_zero", 32'(div_zero), 32'd0);
    check("rst overflow", 32'(overflow), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (40) @(negedge clk);
    do_op(32'd100, 32'd7, 1'b0, 1, 32'd14, 32'd2, 1'b0, 1'b0, W + 1, "post_rst");

    // Random sweep, biased toward the special and boundary cases
    for (int i = 0; i < 40; i++) begin
      ra = $urandom;
      rb = $urandom;
      rs = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 9))
        0: rb = 32'd0;
        1: begin ra = MINV; rb = 32'hFFFF_FFFF; end
        2: rb = 32'($urandom_range(1, 15));
        3: ra = 32'd0;
        4: rb = {28'hFFFF_FFF, 4'($urandom_range(0, 15))};
        default: ;
      endcase
      do_op(ra, rb, rs, 0, '0, '0, 1'b0, 1'b0, 0, "rand");
    end

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

endmodule
